// File: rtl/cosine_stream_ctrl.sv
// Flow-control wrapper for a pipelined cosine core that carries no valid signal.
// It tags samples in flight, buffers results in a FIFO, and only issues an angle when a result slot is guaranteed.
module cosine_stream_ctrl #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_angle,
    output logic [31:0] core_angle,
    output logic        core_clk_en,
    input  logic [31:0] core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy,
    output logic        flush_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0] r_tag;
    logic [LATENCY-1:0] w_tag_next;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic               r_flush_err;
    logic [31:0]        r_fifo [DEPTH];

    logic [CW-1:0]      w_credit;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    // Slots already promised: buffered results plus samples still inside the core.
    assign w_credit    = r_count + r_inflight;
    assign in_ready    = clk_en & ~reset & (w_credit < CW'(DEPTH));
    assign w_accept    = in_valid & in_ready;
    assign w_push      = clk_en & r_tag[LATENCY-1];
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;
    assign out_result  = out_valid ? r_fifo[r_rd_ptr] : 32'h0;
    assign busy        = (r_inflight != '0) | (r_count != '0);
    assign flush_err   = r_flush_err;
    assign core_angle  = in_angle;
    assign core_clk_en = clk_en;

    assign w_tag_next[0] = w_accept;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign w_tag_next[gi] = r_tag[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag       <= '0;
            r_inflight  <= '0;
            r_flush_err <= 1'b0;
        end else if (!clk_en) begin
            // The core clears its pipeline, so every tagged sample is gone.
            r_tag       <= '0;
            r_inflight  <= '0;
            r_flush_err <= r_flush_err | (r_inflight != '0);
        end else begin
            r_tag <= w_tag_next;
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= core_result;
        end
    end

endmodule
